i2c_arbiter: RTL and testbench

I2C_ARBITER -- requirements
Module: i2c_arbiter

---
 rtl/i2c_arbiter.sv | 141 ++++++++++++++
 tb/tb_i2c_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: two-client arbiter in front of one I2C master; define I2C_TIMEOUT_EN to add the watchdog
module i2c_arbiter #(
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic       clk_50,
   input  logic       rst,
   input  logic       c0_req,
   input  logic       c0_wr,
   input  logic [7:0] c0_len,
   input  logic [6:0] c0_addr,
   input  logic [7:0] c0_saddr,
   input  logic [7:0] c0_txdata,
   output logic       c0_tx_ack,
   output logic [7:0] c0_rxdata,
   output logic       c0_rx_valid,
   output logic       c0_done,
   output logic       c0_err,
   input  logic       c1_req,
   input  logic       c1_wr,
   input  logic [7:0] c1_len,
   input  logic [6:0] c1_addr,
   input  logic [7:0] c1_saddr,
   input  logic [7:0] c1_txdata,
   output logic       c1_tx_ack,
   output logic [7:0] c1_rxdata,
   output logic       c1_rx_valid,
   output logic       c1_done,
   output logic       c1_err,
   output logic       m_request,
   output logic       m_WR,
   output logic [7:0] m_length,
   output logic [6:0] m_address,
   output logic [7:0] m_sub_address,
   output logic [7:0] m_txReg,
   input  logic       m_DE,
   input  logic       m_error,
   input  logic [7:0] m_rxReg
);
   typedef enum logic [2:0] {IDLE, GRANT, WAIT_START, XFER, WAIT_IDLE, DONE} state_t;
   state_t state, state_nx;
   logic gnt, ptr, win, any_req, de_q, er_q, de_rise, er_rise, byte_ok, to_hit, to_err;
   logic [1:0] de_s, er_s;
   logic [7:0] cnt;

   assign any_req   = c0_req | c1_req;
   assign win       = c0_req ? (c1_req & ptr) : 1'b1;
   assign de_rise   = de_s[1] & ~de_q;
   assign er_rise   = er_s[1] & ~er_q;
   assign byte_ok   = (state == XFER) && de_rise && (cnt != m_length);
   assign m_request = (state == GRANT);
   assign m_txReg   = gnt ? c1_txdata : c0_txdata;
   assign c0_done   = (state == DONE) & ~gnt;
   assign c1_done   = (state == DONE) & gnt;
   assign c0_err    = c0_done & to_err;
   assign c1_err    = c1_done & to_err;

   // two-flop synchronizers for the master handshakes plus one delay stage for edge detection
   always_ff @(posedge clk_50 or posedge rst)
      if (rst) {de_s, er_s, de_q, er_q} <= '0;
      else begin
         de_s <= {de_s[0], m_DE};
         er_s <= {er_s[0], m_error};
         de_q <= de_s[1];
         er_q <= er_s[1];
      end

   // state register
   always_ff @(posedge clk_50 or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;

   // next state; the watchdog overrides every other transition
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:       if (any_req) state_nx = GRANT;
         GRANT:      if (er_rise) state_nx = WAIT_START;
         WAIT_START: state_nx = (m_length == 8'd0) ? WAIT_IDLE : XFER;
         XFER:       if (cnt == m_length) state_nx = WAIT_IDLE;
         WAIT_IDLE:  if (!er_s[1]) state_nx = DONE;
         default:    state_nx = IDLE;
      endcase
      if (to_hit) state_nx = DONE;
   end

   // grant capture, byte counting, per-client strobes and priority rotation
   always_ff @(posedge clk_50 or posedge rst)
      if (rst) begin
         gnt <= 1'b0;
         ptr <= 1'b0;
         m_WR <= 1'b0;
         m_length <= '0;
         m_address <= '0;
         m_sub_address <= '0;
         cnt <= '0;
         c0_rxdata <= '0;
         c1_rxdata <= '0;
         c0_tx_ack <= 1'b0;
         c1_tx_ack <= 1'b0;
         c0_rx_valid <= 1'b0;
         c1_rx_valid <= 1'b0;
      end else begin
         if (state == IDLE && any_req) begin
            gnt <= win;
            m_WR <= win ? c1_wr : c0_wr;
            m_length <= win ? c1_len : c0_len;
            m_address <= win ? c1_addr : c0_addr;
            m_sub_address <= win ? c1_saddr : c0_saddr;
         end
         if (state == WAIT_START) cnt <= '0;
         else if (byte_ok) cnt <= cnt + 8'd1;
         if (byte_ok && !m_WR && !gnt) c0_rxdata <= m_rxReg;
         if (byte_ok && !m_WR && gnt) c1_rxdata <= m_rxReg;
         c0_tx_ack <= byte_ok & m_WR & ~gnt;
         c1_tx_ack <= byte_ok & m_WR & gnt;
         c0_rx_valid <= byte_ok & ~m_WR & ~gnt;
         c1_rx_valid <= byte_ok & ~m_WR & gnt;
         if (state == DONE) ptr <= ~gnt;
      end

`ifdef I2C_TIMEOUT_EN
   logic [31:0] tcnt;
   assign to_hit = (state != IDLE) && (state != DONE) && (tcnt == 32'(TIMEOUT_CYCLES - 1));

   // watchdog: counts cycles while the master is held, cleared whenever the arbiter is idle
   always_ff @(posedge clk_50 or posedge rst)
      if (rst) begin
         tcnt <= '0;
         to_err <= 1'b0;
      end else if (state == IDLE) begin
         tcnt <= '0;
         to_err <= 1'b0;
      end else if (state != DONE) begin
         tcnt <= tcnt + 32'd1;
         if (to_hit) to_err <= 1'b1;
      end
`else
   assign to_hit = 1'b0;
   assign to_err = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif
endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: directed bench for i2c_arbiter with a simple master model
module tb_i2c_arbiter;
   logic clk_50 = 1'b0, rst = 1'b1;
   logic c0_req = 0, c0_wr = 0, c1_req = 0, c1_wr = 0;
   logic [7:0] c0_len = 0, c0_saddr = 0, c0_txdata = 0, c1_len = 0, c1_saddr = 0, c1_txdata = 0;
   logic [6:0] c0_addr = 0, c1_addr = 0;
   logic c0_tx_ack, c0_rx_valid, c0_done, c0_err, c1_tx_ack, c1_rx_valid, c1_done, c1_err;
   logic [7:0] c0_rxdata, c1_rxdata;
   logic m_request, m_WR, m_DE = 0, m_error = 0;
   logic [7:0] m_length, m_sub_address, m_txReg, m_rxReg = 0;
   logic [6:0] m_address;
   int checks = 0, errors = 0;
   int n_tx0 = 0, n_tx1 = 0, n_rx0 = 0, n_rx1 = 0, n_done0 = 0, n_done1 = 0, n_err0 = 0, n_err1 = 0, addr_bad = 0;
   int order[$];
   logic [7:0] rxv[$];

   i2c_arbiter #(.TIMEOUT_CYCLES(1000)) dut (
      .clk_50(clk_50), .rst(rst),
      .c0_req(c0_req), .c0_wr(c0_wr), .c0_len(c0_len), .c0_addr(c0_addr), .c0_saddr(c0_saddr),
      .c0_txdata(c0_txdata), .c0_tx_ack(c0_tx_ack), .c0_rxdata(c0_rxdata), .c0_rx_valid(c0_rx_valid),
      .c0_done(c0_done), .c0_err(c0_err),
      .c1_req(c1_req), .c1_wr(c1_wr), .c1_len(c1_len), .c1_addr(c1_addr), .c1_saddr(c1_saddr),
      .c1_txdata(c1_txdata), .c1_tx_ack(c1_tx_ack), .c1_rxdata(c1_rxdata), .c1_rx_valid(c1_rx_valid),
      .c1_done(c1_done), .c1_err(c1_err),
      .m_request(m_request), .m_WR(m_WR), .m_length(m_length), .m_address(m_address),
      .m_sub_address(m_sub_address), .m_txReg(m_txReg), .m_DE(m_DE), .m_error(m_error), .m_rxReg(m_rxReg)
   );

   always #10 clk_50 = ~clk_50;

   // pulse monitor sampling just after each active edge
   always @(posedge clk_50) begin
      #1;
      if (c0_tx_ack) n_tx0++;
      if (c1_tx_ack) n_tx1++;
      if (c0_rx_valid) n_rx0++;
      if (c1_rx_valid) begin n_rx1++; rxv.push_back(c1_rxdata); end
      if (c0_done) begin n_done0++; order.push_back(0); end
      if (c1_done) begin n_done1++; order.push_back(1); end
      if (c0_err) n_err0++;
      if (c1_err) n_err1++;
      if (c0_tx_ack && m_address !== 7'h1A) addr_bad++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic set_c(input int n, input logic wr, input logic [7:0] len, input logic [6:0] addr, input logic [7:0] saddr);
      if (n == 0) begin c0_wr = wr; c0_len = len; c0_addr = addr; c0_saddr = saddr; end
      else begin c1_wr = wr; c1_len = len; c1_addr = addr; c1_saddr = saddr; end
   endtask

   // master model; mode 0 drops the finished client's request, 1 keeps both, 2 drops both
   task automatic run_master(input int nb, input logic [23:0] rd, input int mode);
      int t, base;
      base = n_done0 + n_done1;
      t = 0;
      while (!m_request && t < 100) begin @(negedge clk_50); t++; end
      chk("req_seen", m_request, 1);
      m_error = 1;
      t = 0;
      while (m_request && t < 20) begin @(negedge clk_50); t++; end
      chk("req_drop", m_request, 0);
      for (int i = 0; i < nb; i++) begin
         m_rxReg = rd[8*i +: 8];
         repeat (2) @(negedge clk_50);
         m_DE = 1;
         repeat (4) @(negedge clk_50);
         m_DE = 0;
         repeat (4) @(negedge clk_50);
      end
      repeat (4) @(negedge clk_50);
      chk("no_early_done", n_done0 + n_done1, base);
      m_error = 0;
      t = 0;
      while (!(c0_done | c1_done) && t < 20) begin @(negedge clk_50); t++; end
      chk("done_seen", c0_done | c1_done, 1);
      if (mode == 2) begin c0_req = 0; c1_req = 0; end
      else if (mode == 0) begin if (c0_done) c0_req = 0; else c1_req = 0; end
      repeat (3) @(negedge clk_50);
   endtask

   initial begin
      int t;
      repeat (2) @(negedge clk_50);
      chk("rst_req", m_request, 0);
      chk("rst_mbus", {m_WR, m_length, m_address, m_sub_address}, 0);
      chk("rst_c0", {c0_tx_ack, c0_rxdata, c0_rx_valid, c0_done, c0_err}, 0);
      chk("rst_c1", {c1_tx_ack, c1_rxdata, c1_rx_valid, c1_done, c1_err}, 0);
      rst = 0;
      repeat (2) @(negedge clk_50);

      set_c(0, 1, 2, 7'h1A, 8'h0C);
      c0_req = 1;
      run_master(2, 24'h0, 0);
      chk("wr_tx_ack", n_tx0, 2);
      chk("wr_done", n_done0, 1);
      chk("wr_addr_held", addr_bad, 0);
      chk("wr_mbus", {m_WR, m_length, m_address, m_sub_address}, {1'b1, 8'd2, 7'h1A, 8'h0C});
      c0_txdata = 8'h5C;
      #1 chk("txreg_c0", m_txReg, 8'h5C);

      set_c(1, 0, 3, 7'h50, 8'h21);
      c1_req = 1;
      run_master(3, 24'hFF5AA5, 0);
      chk("rd_valid", n_rx1, 3);
      chk("rd_b0", rxv[0], 8'hA5);
      chk("rd_b1", rxv[1], 8'h5A);
      chk("rd_b2", rxv[2], 8'hFF);
      chk("rd_done", n_done1, 1);
      chk("rd_c0_quiet", {n_tx0, n_rx0, n_done0}, {32'd2, 32'd0, 32'd1});
      chk("rd_c0_rxdata", c0_rxdata, 0);
      chk("rd_tx1", n_tx1, 0);
      c1_txdata = 8'h77;
      #1 chk("txreg_c1", m_txReg, 8'h77);

      @(negedge clk_50);
      rst = 1;
      @(negedge clk_50);
      rst = 0;
      order.delete();
      set_c(0, 1, 1, 7'h1A, 8'h01);
      set_c(1, 1, 1, 7'h33, 8'h02);
      c0_req = 1;
      c1_req = 1;
      run_master(1, 24'h0, 1);
      run_master(1, 24'h0, 1);
      run_master(1, 24'h0, 1);
      run_master(1, 24'h0, 2);
      chk("arb_count", order.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("arb_order%0d", i), order[i], i % 2);

      t = n_tx0;
      set_c(0, 1, 0, 7'h1A, 8'h00);
      c0_req = 1;
      run_master(0, 24'h0, 0);
      chk("zero_tx_ack", n_tx0, t);
      chk("zero_done", order[order.size() - 1], 0);
      chk("zero_mlen", m_length, 0);

      t = n_done0 + n_done1;
      set_c(0, 1, 2, 7'h1A, 8'h44);
      c0_req = 1;
      while (!m_request) @(negedge clk_50);
      m_error = 1;
      repeat (6) @(negedge clk_50);
      m_DE = 1;
      repeat (4) @(negedge clk_50);
      m_DE = 0;
      repeat (2) @(negedge clk_50);
      rst = 1;
      @(negedge clk_50);
      chk("mid_rst_mbus", {m_request, m_WR, m_length, m_address, m_sub_address}, 0);
      chk("mid_rst_c0", {c0_tx_ack, c0_rxdata, c0_rx_valid, c0_done, c0_err}, 0);
      m_error = 0;
      c0_req = 0;
      @(negedge clk_50);
      rst = 0;
      repeat (4) @(negedge clk_50);
      chk("mid_rst_no_done", n_done0 + n_done1, t);
      set_c(1, 1, 1, 7'h2B, 8'h09);
      c1_req = 1;
      run_master(1, 24'h0, 0);
      chk("post_rst_done", n_done0 + n_done1, t + 1);
      chk("post_rst_c1", order[order.size() - 1], 1);
      chk("post_rst_addr", m_address, 7'h2B);
      chk("no_err", n_err0 + n_err1, 0);

`ifdef I2C_TIMEOUT_EN
      set_c(0, 1, 1, 7'h1A, 8'h00);
      c0_req = 1;
      t = 0;
      while (!m_request && t < 20) begin @(negedge clk_50); t++; end
      chk("to_req", m_request, 1);
      t = 0;
      while (!c0_done && t < 1100) begin @(negedge clk_50); t++; end
      c0_req = 0;
      chk("to_cycles", t, 1000);
      chk("to_err", c0_err, 1);
      chk("to_req_drop", m_request, 0);
`endif

      repeat (2) @(negedge clk_50);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
